// File: rtl/arb_mux_pkg.sv
// Shared constants and the select-width helper for the arb_mux block.
package arb_mux_pkg;

  localparam int ARB_MUX_WIDTH_DEF = 16;
  localparam int ARB_MUX_NCH_DEF   = 4;
  localparam int STATS_W           = 16;

  // max(1, clog2(n)) so a single-channel build still has a 1-bit index.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Combinational rotated priority encoder: first requester at or above ptr, wrapping.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter  int NCH   = ARB_MUX_NCH_DEF,
  localparam int SEL_W = sel_w(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NCH-1:0]   gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  // Scan a doubled request vector downward; the last hit is the lowest position
  // at or above ptr, which lands inside the wrapped window [ptr, ptr+NCH-1].
  // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int j = 2*NCH-1; j >= 0; j--) begin
      if (req[j % NCH] && (j >= int'(ptr))) begin
        gnt_onehot          = '0;
        gnt_onehot[j % NCH] = 1'b1;
        gnt_idx             = SEL_W'(j % NCH);
        any                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel round-robin registered mux with valid/ready on every port.
// Optional feature: define ARB_MUX_STATS_EN to add the grant_cnt output-beat counter.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH = ARB_MUX_WIDTH_DEF,
  parameter  int NCH   = ARB_MUX_NCH_DEF,
  localparam int SEL_W = sel_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_sel
`ifdef ARB_MUX_STATS_EN
  ,
  output logic [STATS_W-1:0]   grant_cnt
`endif
);

  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_sel;

  logic             w_ld;
  logic [NCH-1:0]   w_gnt_onehot;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_any;
  logic [WIDTH-1:0] w_sel_data;
  logic [SEL_W-1:0] w_ptr_nxt;

  assign w_ld = !r_out_valid || out_ready;

  rr_pick #(.NCH(NCH)) u_pick (
    .req        (in_valid),
    .ptr        (r_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  // Reset masks the grant so no source sees an accept that the register would drop.
  assign in_ready  = (w_ld && !rst) ? w_gnt_onehot : '0;
  assign w_ptr_nxt = (w_gnt_idx == SEL_W'(NCH-1)) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt_onehot[i]) w_sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_ld) begin
      if (w_any) begin
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_gnt_idx;
        r_out_valid <= 1'b1;
        r_ptr       <= w_ptr_nxt;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sel   = r_out_sel;

`ifdef ARB_MUX_STATS_EN
  logic [STATS_W-1:0] r_grant_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt <= '0;
    end else if (r_out_valid && out_ready) begin
      r_grant_cnt <= r_grant_cnt + 1'b1;
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule
